handshake_sender: RTL

//   Single-clock transmitter for the source side of the req/ack handshake synchronizer, in the clk1 domain.

---
 rtl/handshake_sender.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/handshake_sender.sv
// Source side of the req/ack handshake synchronizer: a small FIFO feeding a
// launch FSM that issues one sready pulse per word and waits for a full sidle cycle.
module handshake_sender #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 8,
  parameter int LOW_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             sidle,
  output logic             sready,
  output logic [WIDTH-1:0] din,
  output logic             busy,
  output logic [CNT_W-1:0] tx_count,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int TW = $clog2(LOW_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_LOW  = 2'd2,
    S_WAIT_HIGH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             sready_q, sready_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] tx_count_q, tx_count_d;
  logic             err_q, err_d;
  logic             push_s;
  logic             pop_s;

  assign in_ready = (occ_q != OW'(DEPTH));
  assign push_s   = in_valid & in_ready;
  assign sready   = sready_q;
  assign din      = din_q;
  assign busy     = busy_q;
  assign tx_count = tx_count_q;
  assign err      = err_q;

  // Launch FSM, FIFO pointer bookkeeping and registered output next-state.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    din_d      = din_q;
    tx_count_d = tx_count_q;
    err_d      = err_q;
    pop_s      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sidle && (occ_q != OW'(0))) begin
          state_d = S_LAUNCH;
          din_d   = mem_q[rd_ptr_q];
          pop_s   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        timer_d = TW'(0);
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!sidle) begin
          state_d = S_WAIT_HIGH;
        end else begin
          timer_d = timer_q + TW'(1);
          // An unanswered launch is abandoned so later words are not blocked forever.
          if (timer_d == TW'(LOW_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_LOW;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (sidle) begin
          state_d    = S_IDLE;
          tx_count_d = tx_count_q + CNT_W'(1);
        end else begin
          state_d = S_WAIT_HIGH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    sready_d = (state_d == S_LAUNCH);
    busy_d   = (occ_d != OW'(0)) || (state_d != S_IDLE);
  end

  // State, FIFO storage and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= AW'(0);
      rd_ptr_q   <= AW'(0);
      occ_q      <= OW'(0);
      timer_q    <= TW'(0);
      din_q      <= WIDTH'(0);
      sready_q   <= 1'b0;
      busy_q     <= 1'b0;
      tx_count_q <= CNT_W'(0);
      err_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WIDTH'(0);
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      timer_q    <= timer_d;
      din_q      <= din_d;
      sready_q   <= sready_d;
      busy_q     <= busy_d;
      tx_count_q <= tx_count_d;
      err_q      <= err_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= in_data;
      end
    end
  end

endmodule
